// File: rtl/pi_cmd_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pi_cmd_queue_if                                                            |
// | Command handshake between the Pi command queue and the 68k bus engine.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface pi_cmd_queue_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [2:0]  CMD_FC;
  logic        CMD_RW;
  logic        CMD_UDS_n;
  logic        CMD_LDS_n;
  logic [23:0] CMD_ADDR;
  logic [15:0] CMD_DATA;
  logic        RD_DONE;

  modport master (
    output CMD_VALID, CMD_FC, CMD_RW, CMD_UDS_n, CMD_LDS_n, CMD_ADDR, CMD_DATA,
    input  CMD_READY, RD_DONE
  );

  modport slave (
    input  CMD_VALID, CMD_FC, CMD_RW, CMD_UDS_n, CMD_LDS_n, CMD_ADDR, CMD_DATA,
    output CMD_READY, RD_DONE
  );
endinterface
`default_nettype wire

// File: rtl/pi_cmd_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pi_cmd_queue                                                               |
// | Decodes Pi GPIO register writes into 68k bus commands and posts them       |
// | through a first-word-fall-through FIFO to the bus engine.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pi_cmd_queue #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  PI_CLK,
  input  logic                  RESET_n,
  input  logic [1:0]            PI_A,
  input  logic                  PI_WR,
  input  logic [15:0]           PI_D,
  input  logic                  BUS_FLUSH,
  pi_cmd_queue_if.master        cmd,
  output logic                  PI_TXN_BUSY,
  output logic [DEPTH_LOG2:0]   FIFO_LEVEL,
  output logic                  OVERFLOW
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EW    = 46;

  typedef logic [DEPTH_LOG2:0]   lvl_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  localparam lvl_t FULL = lvl_t'(DEPTH);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_ADDRLO = 2'd1;
  localparam logic [1:0] A_ADDRHI = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic [1:0]    wr_s_q;
  logic [15:0]   data_hold_q;
  logic [15:0]   addr_lo_q;
  logic [EW-1:0] mem_q [DEPTH];
  ptr_t          wr_ptr_q, wr_ptr_d;
  ptr_t          rd_ptr_q, rd_ptr_d;
  lvl_t          level_q, level_d;
  lvl_t          rd_out_q, rd_out_d;
  logic          busy_q;
  logic          ovf_q, ovf_d;

  logic          w_rise;
  logic          w_push;
  logic          w_clear;
  logic          w_valid;
  logic          w_pop;
  logic          w_accept;
  logic          w_drop;
  logic          w_rd_inc;
  logic          w_rd_dec;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;
  logic          w_unused_d;

  assign w_rise  = wr_s_q[0] & ~wr_s_q[1];
  assign w_push  = w_rise & (PI_A == A_ADDRHI);
  assign w_clear = w_rise & (PI_A == A_STATUS);
  assign w_valid = (level_q != '0);
  assign w_pop   = w_valid & cmd.CMD_READY;

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign w_accept = w_push & ~BUS_FLUSH & ((level_q != FULL) | w_pop);
  assign w_drop   = w_push & ~BUS_FLUSH & (level_q == FULL) & ~w_pop;
  assign w_rd_inc = w_accept & PI_D[9] & (rd_out_q != FULL);
  assign w_rd_dec = cmd.RD_DONE & (rd_out_q != '0);

  // Entry layout: {fc, rw, uds_n, lds_n, addr[23:0], data[15:0]}.
  assign w_entry = {PI_D[15:13], PI_D[9],
                    PI_D[8] ? addr_lo_q[0]  : 1'b0,
                    PI_D[8] ? ~addr_lo_q[0] : 1'b0,
                    PI_D[7:0], addr_lo_q, data_hold_q};

  assign w_unused_d = ^PI_D[12:10];

  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rd_out_d = rd_out_q;
    ovf_d    = ovf_q;

    if (w_accept) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (w_pop)    rd_ptr_d = rd_ptr_q + ptr_t'(1);
    if (w_accept && !w_pop)      level_d = level_q + lvl_t'(1);
    else if (!w_accept && w_pop) level_d = level_q - lvl_t'(1);

    if (w_rd_inc && !w_rd_dec)      rd_out_d = rd_out_q + lvl_t'(1);
    else if (!w_rd_inc && w_rd_dec) rd_out_d = rd_out_q - lvl_t'(1);

    if (w_drop)       ovf_d = 1'b1;
    else if (w_clear) ovf_d = 1'b0;

    if (BUS_FLUSH) begin
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      rd_out_d = '0;
    end
  end

  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wr_s_q      <= '0;
      data_hold_q <= '0;
      addr_lo_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_out_q    <= '0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_s_q   <= {wr_s_q[0], PI_WR};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rd_out_q <= rd_out_d;
      ovf_q    <= ovf_d;
      busy_q   <= (level_q == FULL) | (rd_out_q != '0);
      if (w_rise && PI_A == A_DATA)   data_hold_q <= PI_D;
      if (w_rise && PI_A == A_ADDRLO) addr_lo_q   <= PI_D;
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge PI_CLK) begin
    if (w_accept) mem_q[wr_ptr_q] <= w_entry;
  end

  assign w_head = w_valid ? mem_q[rd_ptr_q] : '0;

  assign cmd.CMD_VALID = w_valid;
  assign cmd.CMD_FC    = w_head[45:43];
  assign cmd.CMD_RW    = w_head[42];
  assign cmd.CMD_UDS_n = w_head[41];
  assign cmd.CMD_LDS_n = w_head[40];
  assign cmd.CMD_ADDR  = w_head[39:16];
  assign cmd.CMD_DATA  = w_head[15:0];

  assign PI_TXN_BUSY = busy_q;
  assign FIFO_LEVEL  = level_q;
  assign OVERFLOW    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pi_cmd_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pi_cmd_queue                                                            |
// | Directed self-checking bench for pi_cmd_queue (DEPTH_LOG2 = 2).            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pi_cmd_queue;

  logic        PI_CLK = 1'b0;
  logic        RESET_n;
  logic [1:0]  PI_A;
  logic        PI_WR;
  logic [15:0] PI_D;
  logic        BUS_FLUSH;
  logic        PI_TXN_BUSY;
  logic [2:0]  FIFO_LEVEL;
  logic        OVERFLOW;

  int n_checks = 0;
  int n_errors = 0;

  always #5 PI_CLK = ~PI_CLK;

  pi_cmd_queue_if cmd_if ();

  pi_cmd_queue #(.DEPTH_LOG2(2)) dut (
    .PI_CLK      (PI_CLK),
    .RESET_n     (RESET_n),
    .PI_A        (PI_A),
    .PI_WR       (PI_WR),
    .PI_D        (PI_D),
    .BUS_FLUSH   (BUS_FLUSH),
    .cmd         (cmd_if),
    .PI_TXN_BUSY (PI_TXN_BUSY),
    .FIFO_LEVEL  (FIFO_LEVEL),
    .OVERFLOW    (OVERFLOW)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge PI_CLK);
    PI_A = a; PI_D = d; PI_WR = 1'b1;
    repeat (3) @(negedge PI_CLK);
    PI_WR = 1'b0;
    repeat (2) @(negedge PI_CLK);
  endtask

  // ADDR_HI write whose push edge coincides with a pop (sel=0) or RD_DONE (sel=1).
  task automatic pi_write_hi_with(input logic [15:0] d, input bit sel);
    @(negedge PI_CLK);
    PI_A = 2'd2; PI_D = d; PI_WR = 1'b1;
    @(negedge PI_CLK);
    if (sel) cmd_if.RD_DONE = 1'b1; else cmd_if.CMD_READY = 1'b1;
    @(negedge PI_CLK);
    cmd_if.RD_DONE = 1'b0; cmd_if.CMD_READY = 1'b0;
    @(negedge PI_CLK);
    PI_WR = 1'b0;
    repeat (2) @(negedge PI_CLK);
  endtask

  task automatic pop_one();
    @(negedge PI_CLK);
    cmd_if.CMD_READY = 1'b1;
    @(negedge PI_CLK);
    cmd_if.CMD_READY = 1'b0;
  endtask

  task automatic rd_done_pulse();
    @(negedge PI_CLK);
    cmd_if.RD_DONE = 1'b1;
    @(negedge PI_CLK);
    cmd_if.RD_DONE = 1'b0;
  endtask

  // Entry k: fc=k, write, byte at even address {k, k<<4}, data 0x1000+k.
  function automatic logic [15:0] hi_word(input int k);
    return 16'((k << 13) | 16'h0100 | k);
  endfunction

  task automatic push_entry(input int k);
    pi_write(2'd0, 16'(16'h1000 + k));
    pi_write(2'd1, 16'(k << 4));
    pi_write(2'd2, hi_word(k));
  endtask

  initial begin
    RESET_n = 1'b0; PI_A = '0; PI_WR = 1'b0; PI_D = '0; BUS_FLUSH = 1'b0;
    cmd_if.CMD_READY = 1'b0; cmd_if.RD_DONE = 1'b0;
    repeat (3) @(negedge PI_CLK);
    check_eq("rst_valid", cmd_if.CMD_VALID, 0);
    check_eq("rst_level", FIFO_LEVEL, 0);
    check_eq("rst_busy",  PI_TXN_BUSY, 0);
    check_eq("rst_ovf",   OVERFLOW, 0);
    check_eq("rst_addr",  cmd_if.CMD_ADDR, 0);
    check_eq("rst_data",  cmd_if.CMD_DATA, 0);
    RESET_n = 1'b1;
    @(negedge PI_CLK);

    // Single byte write; an even address selects the upper lane.
    pi_write(2'd0, 16'hBEEF);
    pi_write(2'd1, 16'h1234);
    pi_write(2'd2, 16'h0156);
    check_eq("t1_level", FIFO_LEVEL, 1);
    check_eq("t1_valid", cmd_if.CMD_VALID, 1);
    check_eq("t1_addr",  cmd_if.CMD_ADDR, 32'h561234);
    check_eq("t1_data",  cmd_if.CMD_DATA, 32'hBEEF);
    check_eq("t1_rw",    cmd_if.CMD_RW, 0);
    check_eq("t1_uds",   cmd_if.CMD_UDS_n, 0);
    check_eq("t1_lds",   cmd_if.CMD_LDS_n, 1);
    check_eq("t1_fc",    cmd_if.CMD_FC, 0);
    pop_one();
    check_eq("t1_empty", FIFO_LEVEL, 0);
    check_eq("t1_novld", cmd_if.CMD_VALID, 0);

    // Five pushes into a four-deep FIFO with the engine stalled.
    for (int k = 1; k <= 5; k++) push_entry(k);
    check_eq("t2_level", FIFO_LEVEL, 4);
    check_eq("t2_busy",  PI_TXN_BUSY, 1);
    check_eq("t2_ovf",   OVERFLOW, 1);
    check_eq("t2_head",  cmd_if.CMD_DATA, 32'h1001);
    pi_write(2'd3, 16'h0000);
    check_eq("t2_ovfclr", OVERFLOW, 0);

    // Push on a full FIFO coincident with a pop.
    pi_write(2'd0, 16'h1006);
    pi_write(2'd1, 16'h0060);
    pi_write_hi_with(hi_word(6), 1'b0);
    check_eq("t3_level", FIFO_LEVEL, 4);
    check_eq("t3_ovf",   OVERFLOW, 0);
    check_eq("t3_addr",  cmd_if.CMD_ADDR, 32'h020020);
    check_eq("t3_fc",    cmd_if.CMD_FC, 2);
    begin
      logic [15:0] exp_data [4];
      exp_data[0] = 16'h1002; exp_data[1] = 16'h1003;
      exp_data[2] = 16'h1004; exp_data[3] = 16'h1006;
      for (int i = 0; i < 4; i++) begin
        check_eq($sformatf("t3_order%0d", i), cmd_if.CMD_DATA, 32'(exp_data[i]));
        pop_one();
      end
    end
    repeat (2) @(negedge PI_CLK);
    check_eq("t3_drained", FIFO_LEVEL, 0);
    check_eq("t3_busy",    PI_TXN_BUSY, 0);

    // Word read at 0x200002: both strobes asserted.
    pi_write(2'd1, 16'h0002);
    pi_write(2'd2, 16'h0220);
    check_eq("t4_rw",   cmd_if.CMD_RW, 1);
    check_eq("t4_uds",  cmd_if.CMD_UDS_n, 0);
    check_eq("t4_lds",  cmd_if.CMD_LDS_n, 0);
    check_eq("t4_addr", cmd_if.CMD_ADDR, 32'h200002);
    check_eq("t4_busy", PI_TXN_BUSY, 1);
    pop_one();
    repeat (2) @(negedge PI_CLK);
    check_eq("t4_busy_out", PI_TXN_BUSY, 1);
    pi_write_hi_with(16'h0220, 1'b1);
    check_eq("t4_busy_coinc", PI_TXN_BUSY, 1);
    check_eq("t4_level", FIFO_LEVEL, 1);
    rd_done_pulse();
    repeat (2) @(negedge PI_CLK);
    check_eq("t4_busy_done", PI_TXN_BUSY, 0);
    pop_one();
    rd_done_pulse();
    repeat (2) @(negedge PI_CLK);
    check_eq("t4_no_underflow", PI_TXN_BUSY, 0);

    // Overflow, drain to three, then flush.
    pi_write(2'd0, 16'h5A5A);
    pi_write(2'd1, 16'h0021);
    for (int k = 0; k < 5; k++) pi_write(2'd2, 16'h0177);
    check_eq("t5_ovf", OVERFLOW, 1);
    pop_one();
    check_eq("t5_level3", FIFO_LEVEL, 3);
    @(negedge PI_CLK);
    BUS_FLUSH = 1'b1;
    @(negedge PI_CLK);
    BUS_FLUSH = 1'b0;
    check_eq("t5_level", FIFO_LEVEL, 0);
    check_eq("t5_valid", cmd_if.CMD_VALID, 0);
    repeat (2) @(negedge PI_CLK);
    check_eq("t5_busy",  PI_TXN_BUSY, 0);
    check_eq("t5_ovf_kept", OVERFLOW, 1);
    pi_write(2'd2, 16'h0177);
    check_eq("t5_data_kept", cmd_if.CMD_DATA, 32'h5A5A);
    check_eq("t5_addr_kept", cmd_if.CMD_ADDR, 32'h770021);
    check_eq("t5_uds_odd",   cmd_if.CMD_UDS_n, 1);
    check_eq("t5_lds_odd",   cmd_if.CMD_LDS_n, 0);

    // Asynchronous reset while the engine handshakes at random.
    pi_write(2'd2, 16'h0311);
    check_eq("t6_busy_pre", PI_TXN_BUSY, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge PI_CLK);
      cmd_if.CMD_READY = 1'($urandom_range(0, 1));
    end
    @(posedge PI_CLK);
    #2 RESET_n = 1'b0;
    #1;
    check_eq("t6_valid", cmd_if.CMD_VALID, 0);
    check_eq("t6_level", FIFO_LEVEL, 0);
    check_eq("t6_busy",  PI_TXN_BUSY, 0);
    check_eq("t6_ovf",   OVERFLOW, 0);
    check_eq("t6_addr",  cmd_if.CMD_ADDR, 0);
    check_eq("t6_data",  cmd_if.CMD_DATA, 0);
    cmd_if.CMD_READY = 1'b0;
    repeat (2) @(negedge PI_CLK);
    RESET_n = 1'b1;
    repeat (2) @(negedge PI_CLK);
    check_eq("t6_post_level", FIFO_LEVEL, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
